// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view of the same count.
// Define GRAY_COUNTER_SAT_EN to saturate at the terminal values instead of wrapping.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;
  logic             terminal;

  // Terminal means the next step in the current direction would leave the range.
  assign terminal = up ? (&bin) : ~(|bin);

  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      wrap_next = terminal;
`ifdef GRAY_COUNTER_SAT_EN
      if (!terminal) begin
        bin_next = up ? (bin + ONE) : (bin - ONE);
      end
`else
      bin_next = up ? (bin + ONE) : (bin - ONE);
`endif
    end
  end

  // Gray is derived from bin_next so both registers always describe the same count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= bin_next ^ (bin_next >> 1);
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: a driver pushes model predictions, a monitor pops and checks.
// Honours GRAY_COUNTER_SAT_EN in its reference model.
module tb_gray_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] gray;
  logic [W-1:0] bin;
  logic         wrap;

  // entry: {moved, wrap, gray, bin}
  logic [2*W+1:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  int model  = 0;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .gray(gray), .bin(bin), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic drive(input logic r, input logic l, input int lb, input logic e, input logic u);
    logic w;
    logic moved;
    int   prev;
    @(negedge clk);
    rst = r; load = l; load_bin = W'(lb); en = e; up = u;
    prev = model;
    w = 1'b0;
    if (r) begin
      model = 0;
    end else if (l) begin
      model = lb;
    end else if (e) begin
      if (u) begin
        if (model == MAX) begin
          w = 1'b1;
`ifndef GRAY_COUNTER_SAT_EN
          model = 0;
`endif
        end else begin
          model = model + 1;
        end
      end else begin
        if (model == 0) begin
          w = 1'b1;
`ifndef GRAY_COUNTER_SAT_EN
          model = MAX;
`endif
        end else begin
          model = model - 1;
        end
      end
    end
    moved = !r && !l && e && (model != prev);
    exp_q.push_back({moved, w, W'(to_gray(model)), W'(model)});
  endtask

  initial begin : monitor
    logic [2*W+1:0] e;
    logic [W-1:0]   prev_gray;
    logic [W-1:0]   dec;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bin !== e[W-1:0]) begin
          errors++;
          $display("FAIL bin: got %b expected %b", bin, e[W-1:0]);
        end
        checks++;
        if (gray !== e[2*W-1:W]) begin
          errors++;
          $display("FAIL gray: got %b expected %b", gray, e[2*W-1:W]);
        end
        checks++;
        if (wrap !== e[2*W]) begin
          errors++;
          $display("FAIL wrap: got %b expected %b", wrap, e[2*W]);
        end
        if (e[2*W+1]) begin
          checks++;
          if ($countones(gray ^ prev_gray) != 1) begin
            errors++;
            $display("FAIL one_bit: got %b -> %b expected exactly one bit change", prev_gray, gray);
          end
        end
        dec[W-1] = gray[W-1];
        for (int i = W - 2; i >= 0; i--) dec[i] = dec[i+1] ^ gray[i];
        checks++;
        if (dec !== bin) begin
          errors++;
          $display("FAIL decode: got gray %b decoding to %b expected bin %b", gray, dec, bin);
        end
        prev_gray = gray;
      end
    end
  end

  initial begin : stimulus
    // Reset held with en and load active.
    drive(1, 1, $urandom_range(0, MAX), 1, 1);
    drive(1, 1, $urandom_range(0, MAX), 1, 1);
    // Up sweep through a full wrap.
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 1);
    // Down wrap from 0.
    drive(0, 0, 0, 1, 0);
    // Load beats enable.
    drive(0, 1, 8, 1, 1);
    // Hold at 0101 then mid-run reset with enable.
    drive(0, 1, 5, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, $urandom_range(0, 1));
    drive(1, 0, 0, 1, 1);
    // Terminal behaviour at the top and bottom.
    drive(0, 1, MAX, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    // Direction flip with no dead cycle.
    drive(0, 1, 3, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    // Randomised traffic, biased towards the terminal values.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 9) == 0,
            ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? MAX : 0) : $urandom_range(0, MAX),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
